// File: rtl/core_seq_if.sv
// Instruction-memory fetch channel between the sequencer (master) and memory (slave).
interface core_seq_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/core_seq.sv
// Multi-cycle core sequencer: fetch -> (wait) -> execute -> writeback, with a
// bounded memory wait and terminal HALT/FAULT states that only rst leaves.
module core_seq #(
   parameter logic [31:0] RST_PC  = 32'h8000_0000,
   parameter logic [7:0]  TIMEOUT = 8'd255
) (
   input  logic        clk,
   input  logic        rst,
   core_seq_if.master  imem,
   output logic [31:0] inst,
   input  logic        ex_done,
   input  logic        halt,
   input  logic        jump_en,
   input  logic [31:0] jump_target,
   output logic        wb_en,
   output logic [31:0] pc,
   output logic        pc_en,
   output logic [31:0] instret,
   output logic        fault,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_EXEC  = 3'd3,
      S_WB    = 3'd4,
      S_HALT  = 3'd5,
      S_FAULT = 3'd6
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [7:0]  wait_cnt;
   logic        halt_r;
   logic        jump_r;
   logic [31:0] target_r;
   logic        xfer;
   logic        timed_out;
   logic        misaligned;
   logic        retire;

   // A transfer is data arriving while a fetch is outstanding; rvalid elsewhere is ignored.
   assign xfer       = ((state_q == S_FETCH) && imem.imem_ready && imem.imem_rvalid) ||
                       ((state_q == S_WAIT) && imem.imem_rvalid);
   assign timed_out  = (({1'b0, wait_cnt} + 9'd1) >= {1'b0, TIMEOUT});
   assign misaligned = jump_r && target_r[1];
   assign retire     = (state_q == S_WB) && !misaligned;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: begin
            if (xfer)                 state_d = S_EXEC;
            else if (timed_out)       state_d = S_FAULT;
            else if (imem.imem_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (xfer)           state_d = S_EXEC;
            else if (timed_out) state_d = S_FAULT;
         end
         S_EXEC:  if (ex_done) state_d = S_WB;
         S_WB: begin
            if (misaligned)  state_d = S_FAULT;
            else if (halt_r) state_d = S_HALT;
            else             state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FAULT;
      endcase
   end

   always_comb begin
      imem.imem_req  = (state_q == S_FETCH);
      imem.imem_addr = pc;
      wb_en          = retire;
      pc_en          = retire;
      fault          = (state_q == S_FAULT);
      state          = state_q;
   end

   // The wait budget spans FETCH and WAIT together and restarts on each new fetch.
   always_ff @(posedge clk) begin
      if (rst)                                         wait_cnt <= '0;
      else if (state_d == S_FETCH && state_q != S_FETCH) wait_cnt <= '0;
      else if (state_q == S_FETCH || state_q == S_WAIT)  wait_cnt <= wait_cnt + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)       inst <= '0;
      else if (xfer) inst <= imem.imem_rdata;
   end

   always_ff @(posedge clk) begin
      if (state_q == S_EXEC && ex_done) begin
         halt_r   <= halt;
         jump_r   <= jump_en;
         target_r <= jump_target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= RST_PC;
         instret <= '0;
      end else if (retire) begin
         pc      <= jump_r ? (target_r & ~32'd1) : pc + 32'd4;
         instret <= instret + 32'd1;
      end
   end

endmodule

// File: tb/tb_core_seq.sv
// Randomized bench for core_seq: a transaction-level model predicts every cycle's outputs.
module tb_core_seq;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_EXEC  = 3'd3;
   localparam logic [2:0] ST_WB    = 3'd4;
   localparam logic [2:0] ST_HALT  = 3'd5;
   localparam logic [2:0] ST_FAULT = 3'd6;
   localparam int         TO       = 255;

   logic        clk;
   logic        rst;
   logic [31:0] inst;
   logic        ex_done;
   logic        halt;
   logic        jump_en;
   logic [31:0] jump_target;
   logic        wb_en;
   logic [31:0] pc;
   logic        pc_en;
   logic [31:0] instret;
   logic        fault;
   logic [2:0]  state;

   core_seq_if bus ();

   core_seq dut (
      .clk         (clk),
      .rst         (rst),
      .imem        (bus),
      .inst        (inst),
      .ex_done     (ex_done),
      .halt        (halt),
      .jump_en     (jump_en),
      .jump_target (jump_target),
      .wb_en       (wb_en),
      .pc          (pc),
      .pc_en       (pc_en),
      .instret     (instret),
      .fault       (fault),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // model state
   logic [31:0] m_pc;
   logic [31:0] m_inst;
   logic [31:0] m_instret;
   logic [2:0]  m_state;

   // expected outputs for the current cycle
   logic        chk_en = 1'b0;
   logic [2:0]  exp_state;
   logic        exp_req;
   logic        exp_wb;
   logic        exp_fault;
   logic [31:0] exp_pc;
   logic [31:0] exp_inst;
   logic [31:0] exp_instret;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("state",    {29'd0, state},        {29'd0, exp_state});
         cmp("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
         if (exp_req) cmp("imem_addr", bus.imem_addr, exp_pc);
         cmp("pc",       pc,                    exp_pc);
         cmp("inst",     inst,                  exp_inst);
         cmp("instret",  instret,               exp_instret);
         cmp("wb_en",    {31'd0, wb_en},        {31'd0, exp_wb});
         cmp("pc_en",    {31'd0, pc_en},        {31'd0, exp_wb});
         cmp("fault",    {31'd0, fault},        {31'd0, exp_fault});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_exp(input logic [2:0] st, input logic wb);
      exp_state   = st;
      exp_req     = (st == ST_FETCH);
      exp_wb      = wb;
      exp_fault   = (st == ST_FAULT);
      exp_pc      = m_pc;
      exp_inst    = m_inst;
      exp_instret = m_instret;
   endtask

   task automatic rand_inputs();
      bus.imem_ready  = 1'($urandom);
      bus.imem_rvalid = 1'($urandom);
      bus.imem_rdata  = $urandom;
      ex_done         = 1'($urandom);
      halt            = 1'($urandom);
      jump_en         = 1'($urandom);
      jump_target     = $urandom;
   endtask

   // Leaves the bench in the IDLE cycle's successor (first FETCH cycle).
   task automatic do_reset();
      chk_en = 1'b0;
      rand_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst       = 1'b0;
      m_pc      = 32'h8000_0000;
      m_inst    = 32'd0;
      m_instret = 32'd0;
      m_state   = ST_FETCH;
      set_exp(ST_IDLE, 1'b0);
      chk_en = 1'b1;
      cmp("rst_pc",      pc,                    32'h8000_0000);
      cmp("rst_inst",    inst,                  32'd0);
      cmp("rst_instret", instret,               32'd0);
      cmp("rst_state",   {29'd0, state},        32'd0);
      cmp("rst_fault",   {31'd0, fault},        32'd0);
      cmp("rst_req",     {31'd0, bus.imem_req}, 32'd0);
      tick();
   endtask

   // One instruction from its first FETCH cycle through WB, with the given delays.
   task automatic run_inst(input int d1, input int d2, input int d3, input logic [31:0] word,
                           input logic h, input logic j, input logic [31:0] tgt);
      logic mis;
      for (int i = 0; i < d1; i++) begin
         rand_inputs();
         bus.imem_ready  = 1'b0;
         bus.imem_rvalid = 1'b0;
         set_exp(ST_FETCH, 1'b0);
         tick();
      end
      rand_inputs();
      bus.imem_ready  = 1'b1;
      bus.imem_rvalid = (d2 == 0);
      if (d2 == 0) bus.imem_rdata = word;
      set_exp(ST_FETCH, 1'b0);
      tick();
      for (int i = 1; i <= d2; i++) begin
         rand_inputs();
         bus.imem_rvalid = (i == d2);
         if (i == d2) bus.imem_rdata = word;
         set_exp(ST_WAIT, 1'b0);
         tick();
      end
      m_inst = word;
      for (int i = 0; i <= d3; i++) begin
         rand_inputs();
         ex_done = (i == d3);
         if (i == d3) begin
            halt        = h;
            jump_en     = j;
            jump_target = tgt;
         end
         set_exp(ST_EXEC, 1'b0);
         tick();
      end
      mis = j && tgt[1];
      rand_inputs();
      set_exp(ST_WB, !mis);
      tick();
      if (mis) begin
         m_state = ST_FAULT;
      end else begin
         m_pc      = j ? {tgt[31:1], 1'b0} : m_pc + 32'd4;
         m_instret = m_instret + 32'd1;
         m_state   = h ? ST_HALT : ST_FETCH;
      end
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) begin
         rand_inputs();
         set_exp(m_state, 1'b0);
         tick();
      end
   endtask

   // Fetch that never delivers data; optionally accepted after d1 cycles.
   task automatic run_timeout(input int d1, input logic accept);
      for (int i = 0; i < TO; i++) begin
         rand_inputs();
         bus.imem_rvalid = 1'b0;
         if (!accept || i <= d1) bus.imem_ready = accept && (i == d1);
         set_exp((accept && i > d1) ? ST_WAIT : ST_FETCH, 1'b0);
         tick();
      end
      m_state = ST_FAULT;
   endtask

   initial begin
      int          r;
      logic        h;
      logic        j;
      logic [31:0] tgt;

      rst = 1'b1;
      rand_inputs();

      // sequential zero-wait fetches
      do_reset();
      for (int n = 0; n < 3; n++) run_inst(0, 0, 0, $urandom, 1'b0, 1'b0, 32'd0);
      cmp("seq_pc",      pc,      32'h8000_000C);
      cmp("seq_instret", instret, 32'd3);

      // delayed ready then delayed data
      run_inst(2, 3, 0, 32'h0010_0073, 1'b0, 1'b0, 32'd0);
      cmp("slow_inst", inst, 32'h0010_0073);

      // jump with bit 0 set, then misaligned jump
      run_inst(0, 0, 0, $urandom, 1'b0, 1'b1, 32'h8000_0101);
      cmp("jump_pc", pc, 32'h8000_0100);
      run_inst(1, 1, 2, $urandom, 1'b0, 1'b1, 32'h8000_0102);
      cmp("mis_fault", {31'd0, fault}, 32'd1);
      cmp("mis_pc",    pc,             32'h8000_0100);
      hold(5);

      // memory timeout, then recovery
      do_reset();
      run_timeout(0, 1'b0);
      cmp("to_fault", {31'd0, fault}, 32'd1);
      hold(3);
      do_reset();
      run_inst(0, 0, 0, $urandom, 1'b0, 1'b0, 32'd0);
      run_timeout(3, 1'b1);
      hold(2);

      // halt retires and parks
      do_reset();
      run_inst(1, 0, 1, 32'h0010_0073, 1'b1, 1'b0, 32'd0);
      cmp("halt_instret", instret,        32'd1);
      cmp("halt_state",   {29'd0, state}, {29'd0, ST_HALT});
      hold(22);

      // instret wrap
      do_reset();
      force dut.instret = 32'hFFFF_FFFF;
      #1;
      release dut.instret;
      m_instret = 32'hFFFF_FFFF;
      run_inst(0, 0, 0, $urandom, 1'b0, 1'b0, 32'd0);
      cmp("wrap_instret", instret, 32'd0);

      // reset in WAIT with data arriving the same cycle
      do_reset();
      rand_inputs();
      bus.imem_ready  = 1'b1;
      bus.imem_rvalid = 1'b0;
      set_exp(ST_FETCH, 1'b0);
      tick();
      rand_inputs();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      rst = 1'b1;
      set_exp(ST_WAIT, 1'b0);
      tick();
      rst = 1'b0;
      set_exp(ST_IDLE, 1'b0);
      cmp("rstwait_inst",  inst,           32'd0);
      cmp("rstwait_state", {29'd0, state}, 32'd0);
      tick();
      run_inst(0, 2, 0, 32'h1234_5678, 1'b0, 1'b0, 32'd0);

      // randomized traffic
      do_reset();
      for (int n = 0; n < 150; n++) begin
         r   = int'($urandom_range(0, 19));
         h   = (r == 0);
         j   = (r >= 1 && r <= 7);
         tgt = $urandom;
         if (r >= 1 && r <= 6) tgt[1] = 1'b0;
         if (r == 7)           tgt[1] = 1'b1;
         run_inst(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), $urandom, h, j, tgt);
         if (m_state != ST_FETCH) begin
            hold(3);
            do_reset();
         end
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/core_seq.md
CORE_SEQ -- requirements
Module: core_seq

Interface
REQ-001 SHALL have parameter RST_PC, default 32'h80000000, PC loaded on reset.
REQ-002 SHALL have parameter TIMEOUT, default 8'd255, max cycles waiting on instruction memory.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 imem_req  output  1  fetch request valid.
REQ-007 imem_addr  output  32  fetch address, equals pc.
REQ-008 imem_ready  input  1  memory accepts request this cycle.
REQ-009 imem_rvalid  input  1  imem_rdata valid this cycle.
REQ-010 imem_rdata  input  32  fetched instruction.
REQ-011 inst  output  32  latched instruction to decode/execute.
REQ-012 ex_done  input  1  execute result ready.
REQ-013 halt  input  1  current instruction is ebreak; sampled with ex_done.
REQ-014 jump_en  input  1  current instruction redirects control; sampled with ex_done.
REQ-015 jump_target  input  32  redirect address; sampled with ex_done.
REQ-016 wb_en  output  1  register-file write enable, one-cycle pulse.
REQ-017 pc  output  32  current PC.
REQ-018 pc_en  output  1  one-cycle pulse when pc updates.
REQ-019 instret  output  32  retired-instruction count.
REQ-020 fault  output  1  sticky; set on memory timeout or misaligned target.
REQ-021 state  output  3  FSM state for debug: IDLE=0, FETCH=1, WAIT=2, EXEC=3, WB=4, HALT=5, FAULT=6.

Function
REQ-022 IDLE SHALL last exactly one cycle, then go to FETCH.
REQ-023 FETCH SHALL drive imem_req=1 with imem_addr=pc; it SHALL hold both stable until imem_ready=1.
REQ-024 FETCH with imem_ready=1 and imem_rvalid=0 SHALL go to WAIT; imem_req SHALL drop the next cycle.
REQ-025 FETCH with imem_ready=1 and imem_rvalid=1 in the same cycle SHALL latch inst and go directly to EXEC.
REQ-026 WAIT with imem_rvalid=1 SHALL latch inst<=imem_rdata and go to EXEC; imem_rvalid SHALL be ignored outside FETCH/WAIT.
REQ-027 An 8-bit wait counter SHALL clear on entry to FETCH, increment each cycle in FETCH/WAIT, and on reaching TIMEOUT without a transfer go to FAULT.
REQ-028 EXEC SHALL hold until ex_done=1; it SHALL then register halt, jump_en and jump_target and go to WB.
REQ-029 WB SHALL pulse wb_en=1 and pc_en=1 for exactly one cycle and increment instret by 1, wrapping from 32'hFFFFFFFF to 0.
REQ-030 In WB, pc SHALL be pc+4 when jump_en=0, or {jump_target[31:1],1'b0} when jump_en=1.
REQ-031 WB with jump_en=1 and jump_target[1]=1 SHALL NOT write pc and SHALL NOT pulse wb_en/pc_en; it SHALL go to FAULT with instret unchanged.
REQ-032 WB SHALL go to HALT when the registered halt=1, else to FETCH; the halting instruction still retires.
REQ-033 HALT and FAULT SHALL be terminal until rst; all outputs SHALL hold and imem_req/wb_en/pc_en SHALL be 0.
REQ-034 fault SHALL be 1 exactly while in FAULT.
REQ-035 Minimum instruction latency SHALL be 3 cycles (FETCH, EXEC, WB) with 0-wait memory and ex_done=1 immediately.
REQ-036 inst SHALL change only on an instruction transfer.
REQ-037 The block SHALL be synthesizable and latch-free, with a single always-block per register group.

Reset
REQ-038 On rst the block SHALL set: state=IDLE, pc=RST_PC, inst=0, instret=0, wait counter=0, and all of imem_req, wb_en, pc_en, fault = 0.
REQ-039 rst asserted in any state, including mid-handshake in FETCH/WAIT, HALT and FAULT, SHALL take effect at the next posedge; any pending imem_rvalid SHALL then be discarded.

Verification
REQ-040 Zero-wait memory (imem_ready=imem_rvalid=1), ex_done=1, jump_en=0 -> pc goes 80000000, 80000004, 80000008, one pc_en pulse every 3 cycles, instret=3 after 9 cycles.
REQ-041 imem_ready delayed 2 cycles, then imem_rvalid 3 cycles later with rdata=32'h00100073 -> imem_req high 3 cycles, imem_addr stable, inst=00100073 on EXEC entry.
REQ-042 jump_en=1, jump_target=32'h80000101 -> pc=80000100; jump_target=32'h80000102 -> FAULT, fault=1, pc unchanged, no wb_en pulse.
REQ-043 imem_ready never asserted -> FAULT after exactly 255 FETCH cycles; rst then -> pc=80000000, fault=0, FETCH resumes after one IDLE cycle.
REQ-044 halt=1 with ex_done=1 -> one wb_en pulse, instret+1, state=HALT, imem_req stays 0 for 20+ cycles.
REQ-045 instret preloaded to FFFFFFFF via forced state, one retirement -> instret=0; rst asserted during WAIT with imem_rvalid=1 the same cycle -> inst stays 0.
